// File: rtl/fibo_bcd_converter.sv
// Binary-to-BCD converter for 16-bit Fibonacci results (double-dabble, one bit per cycle).
// Fixed 17-edge latency from load to a one-cycle bcd_valid pulse; loads during a conversion are dropped.
module fibo_bcd_converter #(
   parameter logic BLANK_ZEROS = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [15:0] i_fibo_in,
   input  logic        i_load,
   output logic        o_busy,
   output logic [19:0] o_bcd_out,
   output logic [4:0]  o_digit_en,
   output logic        o_bcd_valid
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_OUTPUT  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_shift;
   logic [19:0] r_scratch;
   logic [3:0]  r_count;
   logic [19:0] r_bcd_out;
   logic [4:0]  r_digit_en;
   logic        r_bcd_valid;
   logic [19:0] w_adj;

   // Digits are corrected independently; a digit <= 9 plus 3 never exceeds 4 bits.
   function automatic logic [19:0] add3_digits(input logic [19:0] d);
      logic [19:0] r;
      r = d;
      for (int i = 0; i < 5; i++) begin
         if (d[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = d[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = d[4*i +: 4];
         end
      end
      return r;
   endfunction

   function automatic logic [4:0] digit_enable(input logic [19:0] b);
      logic [4:0] en;
      if (BLANK_ZEROS) begin
         en[4] = (b[19:16] != 4'd0);
         en[3] = en[4] | (b[15:12] != 4'd0);
         en[2] = en[3] | (b[11:8]  != 4'd0);
         en[1] = en[2] | (b[7:4]   != 4'd0);
         en[0] = 1'b1;
      end else begin
         en = 5'b11111;
      end
      return en;
   endfunction

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode and the add-3 correction of the current scratch.
   always_comb begin
      w_next_state = r_state;
      w_adj        = add3_digits(r_scratch);
      case (r_state)
         S_IDLE: begin
            if (i_load) begin
               w_next_state = S_CONVERT;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_CONVERT: begin
            if (r_count == 4'd15) begin
               w_next_state = S_OUTPUT;
            end else begin
               w_next_state = S_CONVERT;
            end
         end
         S_OUTPUT: w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Datapath: capture, shift/correct, and publish the result.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_shift     <= 16'd0;
         r_scratch   <= 20'd0;
         r_count     <= 4'd0;
         r_bcd_out   <= 20'h00000;
         r_digit_en  <= 5'b00001;
         r_bcd_valid <= 1'b0;
      end else begin
         r_bcd_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_load) begin
                  r_shift   <= i_fibo_in;
                  r_scratch <= 20'd0;
                  r_count   <= 4'd0;
               end
            end
            S_CONVERT: begin
               {r_scratch, r_shift} <= {w_adj[18:0], r_shift, 1'b0};
               r_count              <= r_count + 4'd1;
            end
            S_OUTPUT: begin
               r_bcd_out   <= r_scratch;
               r_digit_en  <= digit_enable(r_scratch);
               r_bcd_valid <= 1'b1;
            end
            default: begin
               r_bcd_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy      = (r_state != S_IDLE);
   assign o_bcd_out   = r_bcd_out;
   assign o_digit_en  = r_digit_en;
   assign o_bcd_valid = r_bcd_valid;

endmodule

// File: tb/tb_fibo_bcd_converter.sv
// Randomized self-checking bench for fibo_bcd_converter; two instances cover both BLANK_ZEROS settings.
// Expected digits come from decimal arithmetic on the input value.
module tb_fibo_bcd_converter;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] fibo_in;
   logic        load;
   logic        busy1, valid1, busy0, valid0;
   logic [19:0] bcd1, bcd0;
   logic [4:0]  en1, en0;

   int n_checks = 0;
   int n_errors = 0;

   logic [19:0] last_bcd;
   logic [4:0]  last_en1, last_en0;

   always #5 clk = ~clk;

   fibo_bcd_converter #(.BLANK_ZEROS(1'b1)) u_dut1 (
      .i_clk(clk), .i_reset(reset), .i_fibo_in(fibo_in), .i_load(load),
      .o_busy(busy1), .o_bcd_out(bcd1), .o_digit_en(en1), .o_bcd_valid(valid1)
   );

   fibo_bcd_converter #(.BLANK_ZEROS(1'b0)) u_dut0 (
      .i_clk(clk), .i_reset(reset), .i_fibo_in(fibo_in), .i_load(load),
      .o_busy(busy0), .o_bcd_out(bcd0), .o_digit_en(en0), .o_bcd_valid(valid0)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] ref_bcd(input int v);
      logic [19:0] r;
      int t;
      r = 20'd0;
      t = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [4:0] ref_en(input int v);
      logic [4:0] e;
      int p;
      e = 5'b00001;
      p = 10;
      for (int i = 1; i < 5; i++) begin
         if (v >= p) e[i] = 1'b1;
         p = p * 10;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_hold(input string tag);
      chk_eq({tag, "_busy"}, {31'd0, busy1}, 32'd0);
      chk_eq({tag, "_valid"}, {31'd0, valid1 | valid0}, 32'd0);
      chk_eq({tag, "_bcd"}, {12'd0, bcd1}, {12'd0, last_bcd});
      chk_eq({tag, "_en1"}, {27'd0, en1}, {27'd0, last_en1});
   endtask

   // Start a conversion of v; if hammer, hold load high with hv during the whole busy window.
   task automatic run_conv(input logic [15:0] v, input bit hammer, input logic [15:0] hv);
      load = 1'b1;
      fibo_in = v;
      tick();
      chk_eq("busy_after_load", {31'd0, busy1}, 32'd1);
      for (int i = 1; i <= 17; i++) begin
         load = hammer;
         fibo_in = hammer ? hv : 16'($urandom);
         tick();
         if (i < 17) begin
            chk_eq("busy_window", {30'd0, busy1, busy0}, 32'd3);
            chk_eq("no_early_valid", {30'd0, valid1, valid0}, 32'd0);
            chk_eq("hold_bcd", {12'd0, bcd1}, {12'd0, last_bcd});
            chk_eq("hold_en", {22'd0, en1, en0}, {22'd0, last_en1, last_en0});
         end else begin
            last_bcd = ref_bcd(int'(v));
            last_en1 = ref_en(int'(v));
            last_en0 = 5'b11111;
            chk_eq("valid_pulse", {30'd0, valid1, valid0}, 32'd3);
            chk_eq("busy_done", {30'd0, busy1, busy0}, 32'd0);
            chk_eq("bcd1", {12'd0, bcd1}, {12'd0, last_bcd});
            chk_eq("bcd0", {12'd0, bcd0}, {12'd0, last_bcd});
            chk_eq("en1", {27'd0, en1}, {27'd0, last_en1});
            chk_eq("en0", {27'd0, en0}, {27'd0, last_en0});
         end
      end
      load = 1'b0;
   endtask

   initial begin
      int fa, fb, ft;
      reset = 1'b1;
      load = 1'b0;
      fibo_in = 16'd0;
      tick();
      tick();
      last_bcd = 20'h00000;
      last_en1 = 5'b00001;
      last_en0 = 5'b00001;
      chk_idle_hold("reset");
      chk_eq("reset_en0", {27'd0, en0}, 32'd1);
      reset = 1'b0;
      tick();

      run_conv(16'd0, 1'b0, 16'd0);
      tick();
      chk_eq("valid_one_cycle", {30'd0, valid1, valid0}, 32'd0);
      run_conv(16'd1597, 1'b0, 16'd0);
      run_conv(16'hFFFF, 1'b0, 16'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle_hold("idle_hold");
      end

      run_conv(16'd89, 1'b1, 16'd144);
      run_conv(16'd144, 1'b0, 16'd0);

      // Abort a conversion of 4181 at edge +8.
      load = 1'b1;
      fibo_in = 16'd4181;
      tick();
      load = 1'b0;
      for (int i = 1; i < 8; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      last_bcd = 20'h00000;
      last_en1 = 5'b00001;
      last_en0 = 5'b00001;
      chk_idle_hold("abort");
      for (int i = 0; i < 12; i++) begin
         tick();
         chk_idle_hold("abort_quiet");
      end
      run_conv(16'd233, 1'b0, 16'd0);

      // load and reset together: no capture.
      reset = 1'b1;
      load = 1'b1;
      fibo_in = 16'd5;
      tick();
      reset = 1'b0;
      load = 1'b0;
      last_bcd = 20'h00000;
      last_en1 = 5'b00001;
      last_en0 = 5'b00001;
      for (int i = 0; i < 18; i++) begin
         tick();
         chk_idle_hold("load_reset");
      end

      fa = 0;
      fb = 1;
      for (int n = 0; n <= 24; n++) begin
         run_conv(16'(fa), 1'b0, 16'd0);
         ft = fa + fb;
         fa = fb;
         fb = ft;
      end

      for (int n = 0; n < 20; n++) begin
         run_conv(16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            tick();
            chk_idle_hold("rand_gap");
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fibo_bcd_converter.md
FIBO_BCD_CONVERTER -- requirements
Module: fibo_bcd_converter

Interface
REQ-001 Parameter: BLANK_ZEROS, default 1, 1 = leading-zero digits masked in digit_en, 0 = digit_en forced to 5'b11111.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 fibo_in  input  16  unsigned binary Fibonacci result from the calculator stage.
REQ-005 load  input  1  strobe; fibo_in valid and to be converted when high.
REQ-006 busy  output  1  high while a conversion is in progress; load ignored.
REQ-007 bcd_out  output  20  five packed BCD digits, [19:16] = ten-thousands ... [3:0] = units.
REQ-008 digit_en  output  5  per-digit display enable, bit i covers bcd_out[4i+3:4i].
REQ-009 bcd_valid  output  1  one-cycle pulse; bcd_out/digit_en just updated.

Function
REQ-010 FSM SHALL have three states: IDLE, CONVERT, OUTPUT; busy SHALL equal (state != IDLE), decoded from the registered state.
REQ-011 In IDLE with load=1 at edge k, the block SHALL capture fibo_in into a 16-bit shift register, clear a 20-bit BCD scratch register and a 4-bit iteration counter, and enter CONVERT.
REQ-012 In IDLE with load=0, state, scratch and outputs SHALL hold.
REQ-013 In CONVERT, each edge SHALL perform one double-dabble step: every scratch digit >= 5 gets +3, then {scratch, shift} shifts left by one, with the shift MSB entering scratch bit 0.
REQ-014 Each CONVERT edge SHALL increment the counter; the step executed with counter == 15 (16th step, edge k+16) SHALL move the FSM to OUTPUT.
REQ-015 In OUTPUT at edge k+17, bcd_out SHALL load the scratch value, digit_en SHALL update, bcd_valid SHALL be registered high, and the FSM SHALL return to IDLE.
REQ-016 bcd_valid SHALL be high for exactly the one cycle following edge k+17 and low otherwise.
REQ-017 Latency SHALL be fixed: bcd_out valid 17 edges after the load edge, independent of value.
REQ-018 load asserted while busy=1 SHALL be ignored, with no queuing, no effect on the running conversion, and no extra bcd_valid.
REQ-019 load in the bcd_valid cycle (FSM in IDLE) SHALL be accepted; the back-to-back conversion period is 18 cycles.
REQ-020 bcd_out and digit_en SHALL hold their last values between conversions, including during busy.
REQ-021 Digit add-3 SHALL operate on 4 bits with no carry between digits; the 20-bit scratch SHALL NOT overflow for any 16-bit input (max 65535 -> 0x65535).
REQ-022 With BLANK_ZEROS=1, digit_en[i] SHALL be 1 iff digit i, or any higher digit, is non-zero; digit_en[0] SHALL always be 1.
REQ-023 With BLANK_ZEROS=0, digit_en SHALL be 5'b11111 after every conversion.
REQ-024 The block SHALL ignore fibo_in whenever load is low or busy is high.

Reset
REQ-025 reset=1 at an edge SHALL force state=IDLE, busy=0, bcd_valid=0, bcd_out=20'h00000, digit_en=5'b00001, and counter, scratch and shift register to 0.
REQ-026 reset SHALL take priority over load and over an in-progress conversion; an aborted conversion SHALL produce no bcd_valid.
REQ-027 load and reset both high at the same edge SHALL leave the block in IDLE with no capture.

Verification
REQ-028 Reset, then load with fibo_in=0 -> busy high for 17 cycles, bcd_valid pulse at edge +17, bcd_out=0x00000, digit_en=00001.
REQ-029 load with fibo_in=16'd1597 -> bcd_out=0x01597, digit_en=01111; with BLANK_ZEROS=0 -> digit_en=11111.
REQ-030 load with fibo_in=16'hFFFF -> bcd_out=0x65535, digit_en=11111, exactly one bcd_valid pulse.
REQ-031 load 16'd89, then load held high for the whole busy window with fibo_in=16'd144 -> one result only, 0x00089; the next load accepted is in the bcd_valid cycle, giving 0x00144 18 cycles later.
REQ-032 reset asserted at edge +8 of a conversion of 16'd4181 -> no bcd_valid, bcd_out=0x00000, busy=0 the next cycle; a new load of 16'd233 then yields 0x00233.
REQ-033 Sweep all Fibonacci values F(0)..F(24) back-to-back -> each bcd_out matches the decimal reference with the 17-edge latency.
